// File: rtl/vproc_pkg.sv
// vproc_pkg: FSM states, command layout, call reasons and byte-lane helper for vproc
package vproc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SCHED, S_WAIT, S_WRITE, S_READ, S_UPD} state_e;
  typedef enum logic [1:0] {RW_NONE, RW_WRITE, RW_READ} rw_e;
  localparam int REASON_ACCESS = 0;
  localparam int REASON_INT = 1;
  localparam int REASON_VACC = 2;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    rw_e         rw;
    logic [11:0] burst;
    logic [15:0] ticks;
  } cmd_t;
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction
endpackage

// File: rtl/vproc_burst_seq.sv
// vproc_burst_seq: burst word counter, address stepping and first/last flags
module vproc_burst_seq #(
  parameter int INCR = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  input  logic        clr,
  input  logic [31:0] load_addr,
  input  logic [11:0] load_burst,
  output logic [31:0] addr,
  output logic [11:0] burst,
  output logic        first,
  output logic        last,
  output logic        more
);
  logic [31:0] addr_q, addr_d;
  logic [11:0] burst_q, burst_d;
  logic        first_q, first_d;
  always_comb begin
    addr_d  = load ? load_addr : adv ? addr_q + 32'(INCR) : addr_q;
    burst_d = load ? load_burst : adv ? burst_q - 12'd1 : clr ? 12'd0 : burst_q;
    first_d = load ? (load_burst != 12'd0) : (adv | clr) ? 1'b0 : first_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      burst_q <= '0;
      first_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      burst_q <= burst_d;
      first_q <= first_d;
    end
  end
  assign addr  = addr_q;
  assign burst = burst_q;
  assign first = first_q;
  assign last  = burst_q == 12'd1;
  assign more  = burst_q > 12'd1;
endmodule

// File: rtl/vproc.sv
// vproc: command-driven 32-bit bus master with ack handshakes; VPROC_BYTE_EN adds the BE port
module vproc
  import vproc_pkg::*;
#(
  parameter int INT_WIDTH       = 3,
  parameter int NODE_WIDTH      = 8,
  parameter int BURST_ADDR_INCR = 1,
  parameter int DISABLE_DELTA   = 0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic [31:0]           Addr,
  output logic                  WE,
  output logic                  RD,
`ifdef VPROC_BYTE_EN
  output logic [3:0]            BE,
`endif
  output logic [11:0]           Burst,
  output logic                  BurstFirst,
  output logic                  BurstLast,
  output logic [31:0]           DataOut,
  input  logic [31:0]           DataIn,
  input  logic                  WRAck,
  input  logic                  RDAck,
  input  logic [INT_WIDTH-1:0]  Interrupt,
  output logic                  Update,
  input  logic                  UpdateResponse,
  input  logic [NODE_WIDTH-1:0] Node,
  // Call side: vs_call bits flag a sched, interrupt or per-word access call this cycle
  output logic [2:0]            vs_call,
  output logic [NODE_WIDTH-1:0] vs_node,
  output logic [INT_WIDTH-1:0]  vs_int,
  output logic [31:0]           vs_rdata,
  input  logic [31:0]           cmd_addr,
  input  logic [31:0]           cmd_data,
`ifdef VPROC_BYTE_EN
  input  logic [3:0]            cmd_be,
`endif
  input  logic [1:0]            cmd_rw,
  input  logic [11:0]           cmd_burst,
  input  logic [15:0]           cmd_ticks
);
  state_e                 state_q, state_d;
  logic                   we_q, we_d, rd_q, rd_d, upd_q, upd_d;
  logic [31:0]            data_q, data_d, rdata_q, rdata_d, wdata;
  logic [15:0]            tick_q, tick_d;
  logic [INT_WIDTH-1:0]   int_q;
  logic                   ack, load, more;
  cmd_t                   cmd;
`ifdef VPROC_BYTE_EN
  logic [3:0]             be_q, be_d;
  assign cmd   = '{cmd_addr, cmd_data, cmd_be, rw_e'(cmd_rw), cmd_burst, cmd_ticks};
  assign wdata = cmd.data;
  assign BE    = be_q;
`else
  // Without byte lanes every write is a full word
  assign cmd   = '{cmd_addr, cmd_data, 4'hf, rw_e'(cmd_rw), cmd_burst, cmd_ticks};
  assign wdata = cmd.data & be_mask(cmd.be);
`endif
  assign ack = (we_q & WRAck) | (rd_q & RDAck);
  vproc_burst_seq #(.INCR(BURST_ADDR_INCR)) u_seq (
    .clk(Clk), .rst(Reset), .load(load), .adv(ack & more), .clr(ack & ~more),
    .load_addr(cmd.addr), .load_burst(cmd.burst),
    .addr(Addr), .burst(Burst), .first(BurstFirst), .last(BurstLast), .more(more)
  );
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    rd_d    = rd_q;
    upd_d   = upd_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    tick_d  = tick_q;
    load    = 1'b0;
`ifdef VPROC_BYTE_EN
    be_d    = be_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_SCHED;
      S_SCHED: begin
        we_d    = cmd.rw == RW_WRITE;
        rd_d    = cmd.rw == RW_READ;
        load    = we_d | rd_d;
        data_d  = load ? wdata : data_q;
        tick_d  = cmd.ticks;
`ifdef VPROC_BYTE_EN
        be_d    = load ? cmd.be : be_q;
`endif
        state_d = we_d ? S_WRITE : rd_d ? S_READ : (cmd.ticks != 16'd0) ? S_WAIT : S_SCHED;
      end
      S_WAIT: begin
        tick_d  = tick_q - 16'd1;
        state_d = (tick_q == 16'd1) ? S_SCHED : S_WAIT;
      end
      S_WRITE, S_READ: if (ack) begin
        rdata_d = rd_q ? DataIn : rdata_q;
        data_d  = more ? cmd_data : data_q;
        we_d    = we_q & more;
        rd_d    = rd_q & more;
        upd_d   = upd_q ^ ~more;
        state_d = more ? state_q : S_UPD;
      end
      S_UPD: state_d = (DISABLE_DELTA != 0 || UpdateResponse == upd_q) ? S_SCHED : S_UPD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge Clk) begin
    int_q <= Interrupt;
    if (Reset) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      upd_q   <= 1'b0;
      data_q  <= '0;
      rdata_q <= '0;
      tick_q  <= '0;
`ifdef VPROC_BYTE_EN
      be_q    <= 4'hf;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      rd_q    <= rd_d;
      upd_q   <= upd_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      tick_q  <= tick_d;
`ifdef VPROC_BYTE_EN
      be_q    <= be_d;
`endif
    end
  end
  assign WE       = we_q;
  assign RD       = rd_q;
  assign DataOut  = data_q;
  assign Update   = upd_q;
  assign vs_call  = Reset ? 3'b000 : {ack, Interrupt != int_q, state_q == S_SCHED};
  assign vs_node  = Node;
  assign vs_int   = Interrupt;
  assign vs_rdata = vs_call[REASON_VACC] ? DataIn : rdata_q;
endmodule

// File: tb/tb_vproc.sv
// tb_vproc: scoreboard bench driving vproc through its call side with directed commands
module tb_vproc;
  import vproc_pkg::*;
  logic        clk, rst, we, rd, bfirst, blast, wrack, rdack, upd, uresp;
  logic [31:0] addr, dout, din, vs_rdata, c_addr, c_data, c_data_r;
  logic [11:0] burst, c_burst;
  logic [2:0]  intr, vs_int, vs_call;
  logic [7:0]  node, vs_node;
  logic [1:0]  c_rw;
  logic [15:0] c_ticks;
`ifdef VPROC_BYTE_EN
  logic [3:0]  be;
`endif
  logic        ack_tie = 1'b1, resp_echo = 1'b1, mem_clr = 1'b1;
  logic [31:0] mem [16];
  int          pass = 0, total = 0, cyc = 0, last = 0;
  bit          skip = 1'b1;

  typedef struct {logic [31:0] a, d; logic [11:0] b; logic f, l, w;} bus_t;
  typedef struct {int gap; logic u, c; logic [31:0] r;} sch_t;
  bus_t       qb[$];
  sch_t       qs[$];
  logic [2:0] qi[$];
  bus_t       eb;
  sch_t       es;

  vproc #(.INT_WIDTH(3), .NODE_WIDTH(8), .BURST_ADDR_INCR(4), .DISABLE_DELTA(0)) dut (
    .Clk(clk), .Reset(rst), .Addr(addr), .WE(we), .RD(rd),
`ifdef VPROC_BYTE_EN
    .BE(be), .cmd_be(4'hf),
`endif
    .Burst(burst), .BurstFirst(bfirst), .BurstLast(blast), .DataOut(dout), .DataIn(din),
    .WRAck(wrack), .RDAck(rdack), .Interrupt(intr), .Update(upd), .UpdateResponse(uresp),
    .Node(node), .vs_call(vs_call), .vs_node(vs_node), .vs_int(vs_int), .vs_rdata(vs_rdata),
    .cmd_addr(c_addr), .cmd_data(c_data), .cmd_rw(c_rw), .cmd_burst(c_burst), .cmd_ticks(c_ticks)
  );

  function automatic logic [31:0] wf(input logic [31:0] a);
    return a ^ 32'h5a5a_0f0f;
  endfunction

  assign wrack  = ack_tie & we;
  assign rdack  = rd;
  assign uresp  = resp_echo & upd;
  assign din    = mem[addr[5:2]];
  assign c_data = (we && burst > 12'd1) ? wf(addr + 32'd4) : c_data_r;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_clr) for (int i = 0; i < 16; i++) mem[i] <= '0;
    else if (we && wrack) mem[addr[5:2]] <= dout;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic fail(input string nm, input string what);
    total++;
    $display("FAIL %s: %s", nm, what);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) skip = 1'b1;
    else begin
      if (vs_call[REASON_VACC]) begin
        if (qb.size() == 0) fail("bus", "got an acked word, want none");
        else begin
          eb = qb.pop_front();
          chk("addr", addr, eb.a);
          chk("burst", 32'(burst), 32'(eb.b));
          chk("first", 32'(bfirst), 32'(eb.f));
          chk("last", 32'(blast), 32'(eb.l));
          chk("we", 32'(we), 32'(eb.w));
          if (eb.w) chk("wdata", dout, eb.d);
        end
      end
      if (vs_call[REASON_INT]) begin
        if (qi.size() == 0) fail("int", "got an interrupt call, want none");
        else chk("int", 32'(vs_int), 32'(qi.pop_front()));
      end
      if (vs_call[REASON_ACCESS]) begin
        if (skip) skip = 1'b0;
        else if (qs.size() == 0) fail("sched", "got a sched call, want none");
        else begin
          es = qs.pop_front();
          if (es.gap != 0) chk("gap", 32'(cyc - last), 32'(es.gap));
          chk("update", 32'(upd), 32'(es.u));
          if (es.c) chk("rdata", vs_rdata, es.r);
        end
        last = cyc;
      end
    end
  end

  task automatic issue(input rw_e rw, input logic [31:0] a, input logic [31:0] d, input logic [11:0] b,
                       input logic [15:0] t, input logic pushb, input int gap, input logic u,
                       input logic c, input logic [31:0] r, input logic pushs);
    int   n = 0;
    bus_t e;
    sch_t s;
    do begin @(posedge clk); #1; n++; end while (!vs_call[REASON_ACCESS] && n < 300);
    if (n >= 300) begin fail("sched_timeout", "got no sched call, want one within 300 cycles"); return; end
    c_rw = rw; c_addr = a; c_data_r = d; c_burst = b; c_ticks = t;
    if (pushb)
      for (int i = 0; i < ((b == 12'd0) ? 1 : int'(b)); i++) begin
        e.a = a + 32'(i * 4);
        e.d = (i == 0) ? d : wf(a + 32'(i * 4));
        e.b = (b == 12'd0) ? 12'd0 : b - 12'(i);
        e.f = (b != 12'd0) && (i == 0);
        e.l = (b != 12'd0) && (i == int'(b) - 1);
        e.w = rw == RW_WRITE;
        qb.push_back(e);
      end
    if (pushs) begin s.gap = gap; s.u = u; s.c = c; s.r = r; qs.push_back(s); end
  endtask

  initial begin
    int n;
    rst = 1'b1; intr = 3'b000; node = 8'h07;
    c_addr = '0; c_data_r = '0; c_rw = '0; c_burst = '0; c_ticks = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_rd", 32'(rd), 0);
    chk("rst_burst", 32'(burst), 0);
    chk("rst_flags", 32'({bfirst, blast}), 0);
    chk("rst_addr", addr, 0);
    chk("rst_dout", dout, 0);
    chk("rst_update", 32'(upd), 0);
    rst = 1'b0; mem_clr = 1'b0;
    issue(RW_WRITE, 32'ha000_0004, 32'h1234_5678, 12'd0, 16'd0, 1, 3, 1, 0, 0, 1);
    issue(RW_READ, 32'ha000_0004, 32'h0, 12'd0, 16'd0, 1, 3, 0, 1, 32'h1234_5678, 1);
    intr = 3'b100; qi.push_back(3'b100);
    issue(RW_WRITE, 32'ha000_0010, wf(32'ha000_0010), 12'd4, 16'd0, 1, 6, 1, 0, 0, 1);
    intr = 3'b000; qi.push_back(3'b000);
    issue(RW_READ, 32'ha000_0010, 32'h0, 12'd2, 16'd0, 1, 4, 0, 1, wf(32'ha000_0014), 1);
    issue(RW_NONE, 32'h0, 32'h0, 12'd0, 16'd5, 0, 6, 0, 0, 0, 1);
    issue(RW_NONE, 32'h0, 32'h0, 12'd0, 16'd0, 0, 1, 0, 0, 0, 1);
    issue(RW_WRITE, 32'hffff_fffc, wf(32'hffff_fffc), 12'd2, 16'd0, 1, 4, 1, 0, 0, 1);
    issue(RW_READ, 32'ha000_0004, 32'h0, 12'd1, 16'd0, 1, 3, 0, 1, 32'h1234_5678, 1);
    ack_tie = 1'b0;
    issue(RW_WRITE, 32'ha000_0008, 32'hdead_beef, 12'd0, 16'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("we_held", 32'(we), 1);
    intr = 3'b001; qi.push_back(3'b001);
    @(posedge clk); #1;
    chk("we_held_int", 32'(we), 1);
    chk("addr_held", addr, 32'ha000_0008);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_we", 32'(we), 0);
    chk("abort_update", 32'(upd), 0);
    chk("abort_burst", 32'(burst), 0);
    @(posedge clk); #1;
    rst = 1'b0; ack_tie = 1'b1; resp_echo = 1'b0;
    issue(RW_WRITE, 32'ha000_000c, 32'hcafe_f00d, 12'd0, 16'd0, 1, 0, 1, 0, 0, 1);
    intr = 3'b000; qi.push_back(3'b000);
    n = 0;
    repeat (12) begin @(posedge clk); #1; if (vs_call[REASON_ACCESS]) n++; end
    chk("stall_sched", 32'(n), 0);
    chk("stall_update", 32'(upd), 1);
    resp_echo = 1'b1;
    issue(RW_NONE, 32'h0, 32'h0, 12'd0, 16'd3, 0, 4, 1, 0, 0, 1);
    issue(RW_NONE, 32'h0, 32'h0, 12'd0, 16'd50, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mem1", mem[1], 32'h1234_5678);
    chk("mem7", mem[7], wf(32'ha000_001c));
    chk("mem_wrap", mem[0], wf(32'h0));
    chk("mem3", mem[3], 32'hcafe_f00d);
    chk("queues_empty", 32'(qb.size() + qs.size() + qi.size()), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
